// File: rtl/rs_param.sv
// Reservation station: dispatches decoded ops into free slots, snoops the CDB
// for operand wakeup and issues the oldest-indexed ready entry to execution.
module rs_param #(
  parameter int RS_SIZE   = 8,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int IMM_W     = 32,
  parameter int ADDR_W    = 32,
  parameter int CDB_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  output logic                       if_idle,
  input  logic                       if_issue_rs,
  input  logic [TAG_W-1:0]           dest_rs,
  input  logic [OP_W-1:0]            op_type_to_rs,
  input  logic [TAG_W-1:0]           tag_rs1_to_rs,
  input  logic [TAG_W-1:0]           tag_rs2_to_rs,
  input  logic [DATA_W-1:0]          data_rs1_to_rs,
  input  logic [DATA_W-1:0]          data_rs2_to_rs,
  input  logic [IMM_W-1:0]           imm_to_rs,
  input  logic [ADDR_W-1:0]          pc_to_rs,
  input  logic [CDB_PORTS-1:0]       cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [OP_W-1:0]            ex_op,
  output logic [DATA_W-1:0]          ex_v1,
  output logic [DATA_W-1:0]          ex_v2,
  output logic [IMM_W-1:0]           ex_imm,
  output logic [ADDR_W-1:0]          ex_pc,
  output logic [TAG_W-1:0]           ex_dest
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy;
  logic [OP_W-1:0]    e_op   [RS_SIZE];
  logic [TAG_W-1:0]   e_q1   [RS_SIZE];
  logic [TAG_W-1:0]   e_q2   [RS_SIZE];
  logic [DATA_W-1:0]  e_v1   [RS_SIZE];
  logic [DATA_W-1:0]  e_v2   [RS_SIZE];
  logic [IMM_W-1:0]   e_imm  [RS_SIZE];
  logic [ADDR_W-1:0]  e_pc   [RS_SIZE];
  logic [TAG_W-1:0]   e_dest [RS_SIZE];

  // {hit, data}; lowest-numbered matching port wins, tag 0 never matches
  function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    if (tag != '0) begin
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == tag)
          r = {1'b1, cdb_data[p*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  logic [DATA_W:0]  wake1 [RS_SIZE];
  logic [DATA_W:0]  wake2 [RS_SIZE];
  logic [DATA_W:0]  cap1;
  logic [DATA_W:0]  cap2;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             out_free;
  logic             dispatch;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wake1[i] = snoop(e_q1[i]);
      wake2[i] = snoop(e_q2[i]);
    end
    cap1 = snoop(tag_rs1_to_rs);
    cap2 = snoop(tag_rs2_to_rs);
  end

  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i])
        free_idx = IDX_W'(i);
      if (busy[i] && e_q1[i] == '0 && e_q2[i] == '0) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign if_idle  = ~&busy;
  assign out_free = !ex_valid || ex_ready;
  assign dispatch = !flush && if_issue_rs && if_idle;

  // Selection sees pre-edge state, so the slot it frees is never the dispatch target
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_v1    <= '0;
      ex_v2    <= '0;
      ex_imm   <= '0;
      ex_pc    <= '0;
      ex_dest  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        e_op[i]   <= '0;
        e_q1[i]   <= '0;
        e_q2[i]   <= '0;
        e_v1[i]   <= '0;
        e_v2[i]   <= '0;
        e_imm[i]  <= '0;
        e_pc[i]   <= '0;
        e_dest[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy     <= '0;
        ex_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && wake1[i][DATA_W]) begin
            e_q1[i] <= '0;
            e_v1[i] <= wake1[i][DATA_W-1:0];
          end
          if (busy[i] && wake2[i][DATA_W]) begin
            e_q2[i] <= '0;
            e_v2[i] <= wake2[i][DATA_W-1:0];
          end
        end
        if (out_free) begin
          if (sel_found) begin
            ex_valid      <= 1'b1;
            ex_op         <= e_op[sel_idx];
            ex_v1         <= e_v1[sel_idx];
            ex_v2         <= e_v2[sel_idx];
            ex_imm        <= e_imm[sel_idx];
            ex_pc         <= e_pc[sel_idx];
            ex_dest       <= e_dest[sel_idx];
            busy[sel_idx] <= 1'b0;
          end else begin
            ex_valid <= 1'b0;
          end
        end
        if (dispatch) begin
          busy[free_idx]   <= 1'b1;
          e_op[free_idx]   <= op_type_to_rs;
          e_imm[free_idx]  <= imm_to_rs;
          e_pc[free_idx]   <= pc_to_rs;
          e_dest[free_idx] <= dest_rs;
          e_q1[free_idx]   <= cap1[DATA_W] ? '0 : tag_rs1_to_rs;
          e_v1[free_idx]   <= cap1[DATA_W] ? cap1[DATA_W-1:0] : data_rs1_to_rs;
          e_q2[free_idx]   <= cap2[DATA_W] ? '0 : tag_rs2_to_rs;
          e_v2[free_idx]   <= cap2[DATA_W] ? cap2[DATA_W-1:0] : data_rs2_to_rs;
        end
      end
    end
  end

endmodule

// File: doc/rs_param.md
RS_PARAM -- requirements
Module: rs_param

Interface
REQ-001 Parameter RS_SIZE, default 8, number of station entries (power of two, 2..32).
REQ-002 Parameter TAG_W, default 4, ROB tag width; tag value 0 means "operand ready, no dependency".
REQ-003 Parameter DATA_W, default 32, operand width; OP_W, default 6, op-type width; IMM_W, default 32; ADDR_W, default 32.
REQ-004 Parameter CDB_PORTS, default 2, number of common-data-bus broadcast ports snooped per cycle.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 rdy  input  1  global enable; low freezes all state.
REQ-008 flush  input  1  misprediction flush, synchronous.
REQ-009 if_idle  output  1  at least one free entry.
REQ-010 if_issue_rs  input  1  dispatch request from decoder.
REQ-011 dest_rs  input  TAG_W  destination ROB tag.
REQ-012 op_type_to_rs  input  OP_W  operation type.
REQ-013 tag_rs1_to_rs / tag_rs2_to_rs  input  TAG_W  source tags.
REQ-014 data_rs1_to_rs / data_rs2_to_rs  input  DATA_W  source values, valid when matching tag is 0.
REQ-015 imm_to_rs  input  IMM_W; pc_to_rs  input  ADDR_W.
REQ-016 cdb_valid  input  CDB_PORTS; cdb_tag  input  CDB_PORTS*TAG_W; cdb_data  input  CDB_PORTS*DATA_W; port p occupies slice p.
REQ-017 ex_valid  output  1; ex_ready  input  1  valid/ready handshake to execution unit.
REQ-018 ex_op  OP_W, ex_v1/ex_v2  DATA_W, ex_imm  IMM_W, ex_pc  ADDR_W, ex_dest  TAG_W  outputs, registered.

Function
REQ-019 if_idle SHALL be combinational: OR of !busy over all entries.
REQ-020 Dispatch accepted when rdy && !flush && if_issue_rs && if_idle; entry = lowest-index free; request with if_idle low SHALL be dropped without state change.
REQ-021 On dispatch, a source whose tag is nonzero and equals a valid cdb_tag in the same cycle SHALL be captured with that cdb_data and tag 0.
REQ-022 Wakeup: every busy entry with nonzero q1/q2 matching a valid cdb_tag SHALL load the data and clear the tag at the edge; if several ports match, lowest port index wins.
REQ-023 Entry ready = busy && q1==0 && q2==0; select = lowest-index ready entry.
REQ-024 Output register loads when (!ex_valid || ex_ready) and a ready entry exists: ex_* take entry fields, ex_valid=1, entry busy cleared same edge.
REQ-025 If (!ex_valid || ex_ready) and no ready entry, ex_valid SHALL go 0; ex_* data hold last values.
REQ-026 While ex_valid && !ex_ready, all ex_* SHALL hold stable.
REQ-027 Latency: entry becoming ready at edge N (dispatch or wakeup) with output register free SHALL present ex_valid=1 after edge N+1; wakeup and selection in one cycle is not required.
REQ-028 Slot freed at edge N is not reusable for a dispatch decided before edge N; dispatch and select in the same cycle touch distinct entries.
REQ-029 Full: all RS_SIZE entries busy gives if_idle=0; one issue restores if_idle=1 the following cycle.
REQ-030 flush SHALL have priority over dispatch, wakeup and select: all busy=0, ex_valid=0 at the edge.
REQ-031 rdy low SHALL suppress dispatch, wakeup, select and flush; outputs hold.

Reset
REQ-032 rst low SHALL immediately clear all busy bits, ex_valid=0 and all ex_* data to 0, so if_idle=1, independent of clk or rdy.
REQ-033 Reset asserted mid-handshake SHALL discard the pending ex output; no entry survives.

Verification
REQ-034 Dispatch tags 0/0, v1=5, v2=7, dest=3, ex_ready=1 -> ex_valid=1, ex_v1=5, ex_v2=7, ex_dest=3 one cycle after dispatch edge.
REQ-035 Dispatch q1=4; two cycles later cdb port1 tag 4 data 0xAA -> ex_v1=0xAA, ex_valid one cycle after broadcast edge.
REQ-036 Dispatch q2=6 in same cycle as cdb tag 6 data 9 -> entry issues with ex_v2=9, no further wakeup needed.
REQ-037 Fill 8 blocked entries -> if_idle=0, ninth request dropped; wake entry 2 -> it issues and if_idle=1 the next cycle.
REQ-038 Hold ex_ready=0 for 3 cycles with 2 ready entries -> ex_* stable; then ex_ready=1 -> entries 0 then 1 issue on consecutive cycles.
REQ-039 flush with 5 busy entries and ex_valid=1 -> next cycle if_idle=1, ex_valid=0; asynchronous rst low mid-cycle -> same result without a clock edge.
